// File: rtl/sid_pkg.sv
// Shared SID types: phase vector, POT block handshake structs and paddle channel state.
package sid;
  localparam int PHI1      = 0;
  localparam int PHI2_PHI1 = 1;
  localparam int PHI2      = 2;
  localparam int PHI1_PHI2 = 3;

  typedef logic [3:0] phase_t;

  typedef struct packed {
    logic [1:0] discharge;
  } pot_o_t;

  typedef struct packed {
    logic [1:0] charged;
  } pot_i_t;

  typedef enum logic [1:0] {IDLE, DISCH, CHARGING, FULL} paddle_state_t;

  localparam logic [7:0] PADDLE_DISCONNECTED = 8'hFF;

  // Targets 0 and 1 both read back as 1, so they are full on the entry tick.
  function automatic logic short_target(input logic [7:0] target);
    return target <= 8'd1;
  endfunction

  // Charged goes high one tick early so the POT counter stops exactly on target.
  function automatic logic charge_match(input logic [7:0] count, input logic [7:0] target);
    return (target != PADDLE_DISCONNECTED) && (count != 8'hFF) &&
           ((count + 8'd1) == (target - 8'd1));
  endfunction
endpackage

// File: rtl/sid_paddle_if.sv
// Position pair handshake between the paddle source and sid_paddle.
interface sid_paddle_if;
  logic [1:0][7:0] pos;
  logic            pos_valid;
  logic            pos_ready;

  modport master (output pos, output pos_valid, input pos_ready);
  modport slave  (input pos, input pos_valid, output pos_ready);
endinterface

// File: rtl/sid_paddle_ch.sv
// One emulated RC paddle channel: charge timer and comparator output.
// state    | meaning
// IDLE     | after reset, no round seen yet
// DISCH    | POT block is discharging the cap
// CHARGING | counting ticks toward target
// FULL     | comparator tripped, charged held high
module sid_paddle_ch
  import sid::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       discharge,
  input  logic       pend_valid,
  input  logic [7:0] pend_target,
  output logic       charged,
  output logic       load
);
  paddle_state_t state_q, state_d;
  logic [7:0]    count_q, count_d;
  logic [7:0]    target_q, target_d;
  logic          charged_q, charged_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      target_q  <= PADDLE_DISCONNECTED;
      charged_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      target_q  <= target_d;
      charged_q <= charged_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    target_d  = target_q;
    charged_d = charged_q;
    load      = 1'b0;
    if (tick) begin
      if (discharge) begin
        state_d   = DISCH;
        count_d   = '0;
        charged_d = 1'b0;
      end else begin
        case (state_q)
          IDLE, DISCH: begin
            state_d   = CHARGING;
            count_d   = '0;
            charged_d = 1'b0;
            if (pend_valid) begin
              target_d = pend_target;
              load     = 1'b1;
            end
            if (short_target(target_d)) begin
              charged_d = 1'b1;
              state_d   = FULL;
            end
          end
          CHARGING: begin
            if (count_q != 8'hFF) count_d = count_q + 8'd1;
            if (charge_match(count_q, target_q)) begin
              charged_d = 1'b1;
              state_d   = FULL;
            end
          end
          FULL:    state_d = FULL;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  assign charged = charged_q;
endmodule

// File: rtl/sid_paddle.sv
// Paddle emulator top: pending position pair, handshake and two RC channels.
module sid_paddle
  import sid::*;
(
  input  logic   clk,
  input  logic   rst,
  input  phase_t phase,
  input  pot_o_t pot_o,
  output pot_i_t pot_i,
  sid_paddle_if.slave pos_bus
);
  logic            tick;
  logic            unused_phase;
  logic            pend_q;
  logic [1:0][7:0] pend_pos_q;
  logic [1:0]      loaded_q;
  logic [1:0]      load;
  logic [1:0]      charged;

  assign tick         = phase[PHI2_PHI1];
  assign unused_phase = ^phase;
  assign pos_bus.pos_ready = ~pend_q;

  // The pair stays pending until each channel has latched it on its own release.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= 1'b0;
      pend_pos_q <= '0;
      loaded_q   <= '0;
    end else if (pend_q) begin
      if (&(loaded_q | load)) begin
        pend_q   <= 1'b0;
        loaded_q <= '0;
      end else begin
        loaded_q <= loaded_q | load;
      end
    end else if (pos_bus.pos_valid) begin
      pend_q     <= 1'b1;
      pend_pos_q <= pos_bus.pos;
      loaded_q   <= '0;
    end
  end

  sid_paddle_ch u_ch0 (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .discharge   (pot_o.discharge[0]),
    .pend_valid  (pend_q & ~loaded_q[0]),
    .pend_target (pend_pos_q[0]),
    .charged     (charged[0]),
    .load        (load[0])
  );

  sid_paddle_ch u_ch1 (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .discharge   (pot_o.discharge[1]),
    .pend_valid  (pend_q & ~loaded_q[1]),
    .pend_target (pend_pos_q[1]),
    .charged     (charged[1]),
    .load        (load[1])
  );

  assign pot_i.charged = charged;
endmodule

// File: tb/tb_sid_paddle.sv
// Bench: sid_paddle driven by a SID timing + POT counter model; checks pot readings.
module tb_sid_paddle;
  import sid::*;

  logic   clk = 1'b0;
  logic   rst;
  phase_t phase;
  pot_o_t pot_o;
  pot_i_t pot_i;
  sid_paddle_if pos_bus ();

  sid_paddle dut (
    .clk     (clk),
    .rst     (rst),
    .phase   (phase),
    .pot_o   (pot_o),
    .pot_i   (pot_i),
    .pos_bus (pos_bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit              run_en = 1'b0;
  int              ph_idx = 0;
  int              tick_cnt = 0;
  int              round_cnt = 0;
  logic [1:0][7:0] cnt;
  logic [1:0][7:0] pot_xy;
  logic [1:0]      charged_seen;

  // SID timing and POT counter: 256 discharge ticks then 256 counting ticks per round.
  initial begin
    phase = '0;
    pot_o.discharge = 2'b11;
    cnt = '0;
    pot_xy = '0;
    charged_seen = '0;
    forever begin
      @(negedge clk);
      charged_seen = charged_seen | pot_i.charged;
      if (!run_en) begin
        phase = '0;
      end else begin
        ph_idx = (ph_idx + 1) % 4;
        phase  = phase_t'(4'b0001 << ph_idx);
        if (ph_idx == PHI2_PHI1) begin
          if (tick_cnt < 256) begin
            pot_o.discharge = 2'b11;
            cnt = '0;
          end else begin
            pot_o.discharge = 2'b00;
            if (tick_cnt == 256) charged_seen = '0;
            for (int c = 0; c < 2; c++)
              if (!pot_i.charged[c] && cnt[c] != 8'hFF) cnt[c] = cnt[c] + 8'd1;
          end
          if (tick_cnt == 511) begin
            pot_xy = cnt;
            round_cnt++;
          end
          tick_cnt = (tick_cnt + 1) % 512;
        end
      end
    end
  end

  task automatic wait_round();
    int start = round_cnt;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (round_cnt != start) return;
    end
    checks++; errors++;
    $display("FAIL wait_round timeout got round %0d want > %0d", round_cnt, start);
  endtask

  task automatic wait_tick(input int n);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (tick_cnt == n) return;
    end
    checks++; errors++;
    $display("FAIL wait_tick timeout got tick %0d want %0d", tick_cnt, n);
  endtask

  task automatic send_pair(input logic [7:0] x, input logic [7:0] y);
    for (int i = 0; i < 3000 && !pos_bus.pos_ready; i++) begin
      @(posedge clk); #1;
    end
    pos_bus.pos = {y, x};
    pos_bus.pos_valid = 1'b1;
    @(posedge clk); #1;
    pos_bus.pos_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (pot_i.charged !== 2'b00) begin
      errors++; $display("FAIL reset_charged got %b want 00", pot_i.charged);
    end
    checks++;
    if (dut.u_ch0.state_q !== IDLE || dut.u_ch1.state_q !== IDLE) begin
      errors++; $display("FAIL reset_state got %0d/%0d want IDLE", dut.u_ch0.state_q, dut.u_ch1.state_q);
    end
    checks++;
    if (dut.u_ch0.target_q !== 8'hFF || dut.u_ch1.target_q !== 8'hFF) begin
      errors++; $display("FAIL reset_target got %h/%h want ff/ff", dut.u_ch0.target_q, dut.u_ch1.target_q);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (pos_bus.pos_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b want 1", pos_bus.pos_ready);
    end
    run_en = 1'b1;
    wait_round();
    checks++;
    if (pot_xy !== 16'hFFFF) begin
      errors++; $display("FAIL reset_round got %h want ffff", pot_xy);
    end
  endtask

  task automatic test_basic();
    send_pair(8'h40, 8'hC8);
    checks++;
    if (pos_bus.pos_ready !== 1'b0) begin
      errors++; $display("FAIL basic_ready_low got %b want 0", pos_bus.pos_ready);
    end
    wait_round();
    checks++;
    if (pot_xy !== 16'hC840) begin
      errors++; $display("FAIL basic_pot got %h want c840", pot_xy);
    end
    checks++;
    if (pos_bus.pos_ready !== 1'b1) begin
      errors++; $display("FAIL basic_ready_high got %b want 1", pos_bus.pos_ready);
    end
  endtask

  task automatic test_boundaries();
    send_pair(8'h00, 8'h01);
    wait_round();
    checks++;
    if (pot_xy !== 16'h0101) begin
      errors++; $display("FAIL bound_0_1 got %h want 0101", pot_xy);
    end
    send_pair(8'hFE, 8'hFF);
    wait_round();
    checks++;
    if (pot_xy !== 16'hFFFE) begin
      errors++; $display("FAIL bound_fe_ff got %h want fffe", pot_xy);
    end
    checks++;
    if (charged_seen !== 2'b01) begin
      errors++; $display("FAIL bound_charged_seen got %b want 01", charged_seen);
    end
  endtask

  task automatic test_handshake();
    bit accepted = 1'b0;
    int acc_tick = -1;
    send_pair(8'h40, 8'hC8);
    wait_tick(300);
    checks++;
    if (pos_bus.pos_ready !== 1'b1) begin
      errors++; $display("FAIL hs_ready_mid got %b want 1", pos_bus.pos_ready);
    end
    send_pair(8'h10, 8'h20);
    checks++;
    if (pos_bus.pos_ready !== 1'b0) begin
      errors++; $display("FAIL hs_ready_pending got %b want 0", pos_bus.pos_ready);
    end
    pos_bus.pos = {8'h30, 8'h30};
    pos_bus.pos_valid = 1'b1;
    for (int i = 0; i < 6000 && !accepted; i++) begin
      if (pos_bus.pos_ready) begin
        @(posedge clk); #1;
        accepted = 1'b1;
        acc_tick = tick_cnt;
      end else begin
        @(posedge clk); #1;
      end
    end
    pos_bus.pos_valid = 1'b0;
    checks++;
    if (!accepted || acc_tick != 257) begin
      errors++; $display("FAIL hs_accept_tick got %0d want 257", acc_tick);
    end
    checks++;
    if (pot_xy !== 16'hC840) begin
      errors++; $display("FAIL hs_old_round got %h want c840", pot_xy);
    end
    wait_round();
    checks++;
    if (pot_xy !== 16'h2010) begin
      errors++; $display("FAIL hs_first_pair got %h want 2010", pot_xy);
    end
    wait_round();
    checks++;
    if (pot_xy !== 16'h3030) begin
      errors++; $display("FAIL hs_second_pair got %h want 3030", pot_xy);
    end
  endtask

  task automatic test_reset_mid();
    send_pair(8'h80, 8'h80);
    wait_tick(300);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (pot_i.charged !== 2'b00) begin
      errors++; $display("FAIL rstmid_charged got %b want 00", pot_i.charged);
    end
    checks++;
    if (dut.u_ch0.target_q !== 8'hFF || dut.u_ch1.target_q !== 8'hFF) begin
      errors++; $display("FAIL rstmid_target got %h/%h want ff/ff", dut.u_ch0.target_q, dut.u_ch1.target_q);
    end
    checks++;
    if (pos_bus.pos_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_ready got %b want 1", pos_bus.pos_ready);
    end
    wait_round();
    wait_round();
    checks++;
    if (pot_xy !== 16'hFFFF) begin
      errors++; $display("FAIL rstmid_round got %h want ffff", pot_xy);
    end
    checks++;
    if (charged_seen !== 2'b00) begin
      errors++; $display("FAIL rstmid_charged_seen got %b want 00", charged_seen);
    end
  endtask

  task automatic test_stall();
    bit stall_ok = 1'b1;
    send_pair(8'h10, 8'h20);
    wait_tick(400);
    checks++;
    if (pot_i.charged !== 2'b11) begin
      errors++; $display("FAIL stall_full got %b want 11", pot_i.charged);
    end
    run_en = 1'b0;
    repeat (100) begin
      @(posedge clk); #1;
      if (pot_i.charged !== 2'b11 || dut.u_ch0.state_q !== FULL || dut.u_ch1.state_q !== FULL)
        stall_ok = 1'b0;
    end
    checks++;
    if (!stall_ok) begin
      errors++; $display("FAIL stall_hold got %b want 11 and FULL", pot_i.charged);
    end
    run_en = 1'b1;
    wait_round();
    checks++;
    if (pot_xy !== 16'h2010) begin
      errors++; $display("FAIL stall_round got %h want 2010", pot_xy);
    end
    wait_tick(2);
    checks++;
    if (pot_i.charged !== 2'b00) begin
      errors++; $display("FAIL stall_discharge got %b want 00", pot_i.charged);
    end
    checks++;
    if (dut.u_ch0.state_q !== DISCH || dut.u_ch1.state_q !== DISCH) begin
      errors++; $display("FAIL stall_state got %0d/%0d want DISCH", dut.u_ch0.state_q, dut.u_ch1.state_q);
    end
  endtask

  initial begin
    rst = 1'b1;
    pos_bus.pos = '0;
    pos_bus.pos_valid = 1'b0;
    test_reset();
    test_basic();
    test_boundaries();
    test_handshake();
    test_reset_mid();
    test_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
